// File: rtl/buffer_pkg.sv
// Shared types and cartridge address-map defaults for the frame-buffer arbiter.
package buffer_pkg;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_READY   = 2'd2,
    ST_READING = 2'd3
  } frame_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return 32'($clog2(n));
  endfunction

  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_ADDR_W = 26;

  // Channel 0 (video) in the LSBs, then sound L, sound R.
  localparam logic [DEF_NUM_CH*DEF_ADDR_W-1:0] DEF_CH_BASE =
    {26'h01F00000, 26'h01E00000, 26'h01000000};
  localparam logic [DEF_NUM_CH*5-1:0] DEF_CH_STRIDE_LOG2 = {5'd4, 5'd4, 5'd17};

endpackage

// File: rtl/buffer_channel.sv
// One channel's frame-state table, producer/consumer handshakes, drop counter and error flag.
module buffer_channel
  import buffer_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = 3,
  parameter int unsigned ADDR_W      = 26,
  parameter logic [ADDR_W-1:0] BASE  = '0,
  parameter int unsigned STRIDE_LOG2 = 4,
  parameter int unsigned DROP_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_acq,
  input  logic              prod_commit,
  input  logic              cons_acq,
  input  logic              cons_rel,
  output logic              prod_valid,
  output logic [ADDR_W-1:0] prod_addr,
  output logic              cons_valid,
  output logic [ADDR_W-1:0] cons_addr,
  output logic              fresh,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              proto_err
);

  localparam int unsigned IW = idx_w(NUM_FRAMES);

  frame_state_e      st_q [NUM_FRAMES];
  frame_state_e      st_d [NUM_FRAMES];
  logic              prod_valid_d, cons_valid_d, fresh_d, proto_err_d;
  logic [ADDR_W-1:0] prod_addr_d, cons_addr_d;
  logic [DROP_W-1:0] drop_cnt_d;
  logic              ready_hit, free_hit, dropped;
  logic [IW-1:0]     ready_idx, free_idx;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [IW-1:0] idx);
    return BASE + (ADDR_W'(idx) << STRIDE_LOG2);
  endfunction

  always_comb begin
    st_d         = st_q;
    prod_valid_d = prod_valid;
    prod_addr_d  = prod_addr;
    cons_valid_d = cons_valid;
    cons_addr_d  = cons_addr;
    drop_cnt_d   = drop_cnt;
    proto_err_d  = proto_err;
    fresh_d      = 1'b0;
    ready_hit    = 1'b0;
    ready_idx    = '0;
    free_hit     = 1'b0;
    free_idx     = '0;
    dropped      = 1'b0;

    for (int i = 0; i < int'(NUM_FRAMES); i++) begin
      if (st_q[i] == ST_READY) begin
        ready_hit = 1'b1;
        ready_idx = IW'(i);
      end
    end

    // Consumer resolves first so it claims the pre-edge READY frame.
    if (cons_acq) begin
      if (ready_hit) begin
        for (int i = 0; i < int'(NUM_FRAMES); i++) begin
          if (st_q[i] == ST_READING) st_d[i] = ST_FREE;
          else if (IW'(i) == ready_idx) st_d[i] = ST_READING;
        end
        cons_valid_d = 1'b1;
        cons_addr_d  = frame_addr(ready_idx);
      end
    end else if (cons_rel) begin
      if (cons_valid) begin
        for (int i = 0; i < int'(NUM_FRAMES); i++) begin
          if (st_q[i] == ST_READING) st_d[i] = ST_FREE;
        end
        cons_valid_d = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    // A READY frame still unclaimed at commit time is overwritten.
    if (prod_commit) begin
      if (prod_valid) begin
        for (int i = 0; i < int'(NUM_FRAMES); i++) begin
          if (st_d[i] == ST_READY) begin
            st_d[i] = ST_FREE;
            dropped = 1'b1;
          end
        end
        for (int i = 0; i < int'(NUM_FRAMES); i++) begin
          if (st_q[i] == ST_WRITING) st_d[i] = ST_READY;
        end
        if (dropped && (drop_cnt != '1)) drop_cnt_d = drop_cnt + DROP_W'(1);
        prod_valid_d = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    if (prod_acq) begin
      if (prod_valid && !prod_commit) begin
        proto_err_d = 1'b1;
      end else begin
        for (int i = int'(NUM_FRAMES) - 1; i >= 0; i--) begin
          if (st_d[i] == ST_FREE) begin
            free_hit = 1'b1;
            free_idx = IW'(i);
          end
        end
        if (free_hit) begin
          for (int i = 0; i < int'(NUM_FRAMES); i++) begin
            if (IW'(i) == free_idx) st_d[i] = ST_WRITING;
          end
          prod_valid_d = 1'b1;
          prod_addr_d  = frame_addr(free_idx);
        end
      end
    end

    for (int i = 0; i < int'(NUM_FRAMES); i++) begin
      if (st_d[i] == ST_READY) fresh_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_FRAMES); i++) st_q[i] <= ST_FREE;
      prod_valid <= 1'b0;
      prod_addr  <= BASE;
      cons_valid <= 1'b0;
      cons_addr  <= BASE;
      fresh      <= 1'b0;
      drop_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      st_q       <= st_d;
      prod_valid <= prod_valid_d;
      prod_addr  <= prod_addr_d;
      cons_valid <= cons_valid_d;
      cons_addr  <= cons_addr_d;
      fresh      <= fresh_d;
      drop_cnt   <= drop_cnt_d;
      proto_err  <= proto_err_d;
    end
  end

endmodule

// File: rtl/multi_buffer_arbiter.sv
// N-channel frame-buffer arbiter: one independent buffer_channel per feed, outputs packed per channel.
module multi_buffer_arbiter
  import buffer_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned NUM_FRAMES = 3,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE        = DEF_CH_BASE,
  parameter logic [NUM_CH*5-1:0]      CH_STRIDE_LOG2 = DEF_CH_STRIDE_LOG2,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        prod_acq,
  input  logic [NUM_CH-1:0]        prod_commit,
  input  logic [NUM_CH-1:0]        cons_acq,
  input  logic [NUM_CH-1:0]        cons_rel,
  output logic [NUM_CH-1:0]        prod_valid,
  output logic [NUM_CH*ADDR_W-1:0] prod_addr,
  output logic [NUM_CH-1:0]        cons_valid,
  output logic [NUM_CH*ADDR_W-1:0] cons_addr,
  output logic [NUM_CH-1:0]        fresh,
  output logic [NUM_CH*DROP_W-1:0] drop_cnt,
  output logic [NUM_CH-1:0]        proto_err
);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    buffer_channel #(
      .NUM_FRAMES  (NUM_FRAMES),
      .ADDR_W      (ADDR_W),
      .BASE        (CH_BASE[g*ADDR_W +: ADDR_W]),
      .STRIDE_LOG2 (32'(CH_STRIDE_LOG2[g*5 +: 5])),
      .DROP_W      (DROP_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .prod_acq    (prod_acq[g]),
      .prod_commit (prod_commit[g]),
      .cons_acq    (cons_acq[g]),
      .cons_rel    (cons_rel[g]),
      .prod_valid  (prod_valid[g]),
      .prod_addr   (prod_addr[g*ADDR_W +: ADDR_W]),
      .cons_valid  (cons_valid[g]),
      .cons_addr   (cons_addr[g*ADDR_W +: ADDR_W]),
      .fresh       (fresh[g]),
      .drop_cnt    (drop_cnt[g*DROP_W +: DROP_W]),
      .proto_err   (proto_err[g])
    );
  end

endmodule

// File: tb/tb_multi_buffer_arbiter.sv
// Bench for multi_buffer_arbiter: directed handshake scenarios plus randomized traffic against a frame-ownership model.
module tb_multi_buffer_arbiter;

  localparam int unsigned NCH = 3;
  localparam int unsigned NF  = 3;
  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 4;
  localparam int          DMAX = (1 << DW) - 1;
  localparam logic [NCH*AW-1:0] BASE_PACK = {26'h01F00000, 26'h01E00000, 26'h01000000};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    prod_acq, prod_commit, cons_acq, cons_rel;
  logic [NCH-1:0]    prod_valid, cons_valid, fresh, proto_err;
  logic [NCH*AW-1:0] prod_addr, cons_addr;
  logic [NCH*DW-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  // Model: which frame index each role owns (-1 = none).
  int m_w    [NCH];
  int m_r    [NCH];
  int m_c    [NCH];
  int m_drop [NCH];
  bit m_err  [NCH];

  multi_buffer_arbiter #(
    .NUM_CH     (NCH),
    .NUM_FRAMES (NF),
    .ADDR_W     (AW),
    .DROP_W     (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prod_acq    (prod_acq),
    .prod_commit (prod_commit),
    .cons_acq    (cons_acq),
    .cons_rel    (cons_rel),
    .prod_valid  (prod_valid),
    .prod_addr   (prod_addr),
    .cons_valid  (cons_valid),
    .cons_addr   (cons_addr),
    .fresh       (fresh),
    .drop_cnt    (drop_cnt),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] exp_addr(input int c, input int idx);
    int unsigned base_v [NCH];
    int unsigned str_v  [NCH];
    base_v = '{32'h01000000, 32'h01E00000, 32'h01F00000};
    str_v  = '{17, 4, 4};
    return AW'(base_v[c] + idx * (1 << str_v[c]));
  endfunction

  function automatic logic [AW-1:0] paddr(input int c);
    return prod_addr[c*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] caddr(input int c);
    return cons_addr[c*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] dcnt(input int c);
    return drop_cnt[c*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_w[c] = -1; m_r[c] = -1; m_c[c] = -1; m_drop[c] = 0; m_err[c] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] pa, pc, ca, cr);
    for (int c = 0; c < NCH; c++) begin
      if (ca[c]) begin
        if (m_r[c] >= 0) begin m_c[c] = m_r[c]; m_r[c] = -1; end
      end else if (cr[c]) begin
        if (m_c[c] >= 0) m_c[c] = -1;
        else m_err[c] = 1'b1;
      end
      if (pc[c]) begin
        if (m_w[c] >= 0) begin
          if (m_r[c] >= 0 && m_drop[c] < DMAX) m_drop[c]++;
          m_r[c] = m_w[c];
          m_w[c] = -1;
        end else begin
          m_err[c] = 1'b1;
        end
      end
      if (pa[c]) begin
        if (m_w[c] >= 0) m_err[c] = 1'b1;
        else
          for (int f = 0; f < NF; f++)
            if (m_w[c] < 0 && f != m_r[c] && f != m_c[c]) m_w[c] = f;
      end
    end
  endtask

  task automatic apply_reset();
    prod_acq = '0; prod_commit = '0; cons_acq = '0; cons_rel = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs are applied at a falling edge, sampled by the DUT on the rising edge.
  task automatic cycle(input logic [NCH-1:0] pa, pc, ca, cr);
    prod_acq = pa; prod_commit = pc; cons_acq = ca; cons_rel = cr;
    @(posedge clk);
    model_step(pa, pc, ca, cr);
    @(negedge clk);
    prod_acq = '0; prod_commit = '0; cons_acq = '0; cons_rel = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (prod_valid !== 3'b000 || cons_valid !== 3'b000) begin
      bad++; $display("FAIL reset_valid prod=%b cons=%b exp=000/000", prod_valid, cons_valid);
    end
    total++; if (fresh !== 3'b000 || proto_err !== 3'b000 || drop_cnt !== '0) begin
      bad++; $display("FAIL reset_flags fresh=%b err=%b drop=%h exp=0", fresh, proto_err, drop_cnt);
    end
    total++; if (prod_addr !== BASE_PACK || cons_addr !== BASE_PACK) begin
      bad++; $display("FAIL reset_addr prod=%h cons=%h exp=%h", prod_addr, cons_addr, BASE_PACK);
    end
  endtask

  task automatic test_prod_acq();
    apply_reset();
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    total++; if (prod_valid !== 3'b001) begin
      bad++; $display("FAIL acq_valid got=%b exp=001", prod_valid);
    end
    total++; if (paddr(0) !== 26'h01000000) begin
      bad++; $display("FAIL acq_addr0 got=%h exp=01000000", paddr(0));
    end
    total++; if (paddr(1) !== 26'h01E00000 || paddr(2) !== 26'h01F00000 || cons_valid !== 3'b000) begin
      bad++; $display("FAIL acq_other_ch got=%h/%h cv=%b", paddr(1), paddr(2), cons_valid);
    end
  endtask

  // Continues from test_prod_acq: ch0 producer holds frame 0.
  task automatic test_drop_and_consume();
    cycle(3'b000, 3'b001, 3'b000, 3'b000);
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    total++; if (paddr(0) !== 26'h01020000) begin
      bad++; $display("FAIL second_acq_addr got=%h exp=01020000", paddr(0));
    end
    cycle(3'b000, 3'b001, 3'b000, 3'b000);
    total++; if (dcnt(0) !== 4'd1 || fresh[0] !== 1'b1) begin
      bad++; $display("FAIL drop_one drop=%0d fresh=%b exp=1/1", dcnt(0), fresh[0]);
    end
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    total++; if (paddr(0) !== 26'h01000000 || prod_valid[0] !== 1'b1) begin
      bad++; $display("FAIL reuse_freed got=%h v=%b exp=01000000/1", paddr(0), prod_valid[0]);
    end
    cycle(3'b000, 3'b000, 3'b001, 3'b000);
    total++; if (caddr(0) !== 26'h01020000 || cons_valid[0] !== 1'b1 || fresh[0] !== 1'b0) begin
      bad++; $display("FAIL cons_take got=%h v=%b fresh=%b exp=01020000/1/0", caddr(0), cons_valid[0], fresh[0]);
    end
    cycle(3'b000, 3'b000, 3'b001, 3'b000);
    total++; if (caddr(0) !== 26'h01020000 || cons_valid[0] !== 1'b1) begin
      bad++; $display("FAIL cons_repeat got=%h v=%b exp=01020000/1", caddr(0), cons_valid[0]);
    end
  endtask

  task automatic test_commit_with_cons_acq();
    apply_reset();
    cycle(3'b010, 3'b000, 3'b000, 3'b000);
    cycle(3'b000, 3'b010, 3'b000, 3'b000);
    cycle(3'b010, 3'b000, 3'b000, 3'b000);
    total++; if (paddr(1) !== 26'h01E00010) begin
      bad++; $display("FAIL ch1_acq2 got=%h exp=01E00010", paddr(1));
    end
    cycle(3'b000, 3'b010, 3'b010, 3'b000);
    total++; if (caddr(1) !== 26'h01E00000 || cons_valid[1] !== 1'b1) begin
      bad++; $display("FAIL same_cycle_cons got=%h v=%b exp=01E00000/1", caddr(1), cons_valid[1]);
    end
    total++; if (fresh[1] !== 1'b1 || dcnt(1) !== 4'd0 || prod_valid[1] !== 1'b0) begin
      bad++; $display("FAIL same_cycle_ready fresh=%b drop=%0d pv=%b exp=1/0/0", fresh[1], dcnt(1), prod_valid[1]);
    end
  endtask

  task automatic test_proto_err();
    apply_reset();
    cycle(3'b000, 3'b100, 3'b000, 3'b000);
    total++; if (proto_err !== 3'b100) begin
      bad++; $display("FAIL err_commit got=%b exp=100", proto_err);
    end
    cycle(3'b000, 3'b000, 3'b000, 3'b100);
    total++; if (proto_err !== 3'b100 || prod_valid !== 3'b000 || cons_valid !== 3'b000 || fresh !== 3'b000) begin
      bad++; $display("FAIL err_rel err=%b pv=%b cv=%b fr=%b", proto_err, prod_valid, cons_valid, fresh);
    end
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    repeat (5) cycle(3'b000, 3'b000, 3'b000, 3'b000);
    total++; if (proto_err !== 3'b101 || paddr(0) !== 26'h01000000) begin
      bad++; $display("FAIL err_double_acq err=%b addr=%h exp=101/01000000", proto_err, paddr(0));
    end
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    for (int k = 1; k <= 20; k++) begin
      cycle(3'b001, 3'b001, 3'b000, 3'b000);
      if (k == 15) begin
        total++; if (dcnt(0) !== 4'd14) begin
          bad++; $display("FAIL drop_count14 got=%0d exp=14", dcnt(0));
        end
      end
    end
    total++; if (dcnt(0) !== 4'hF || prod_valid[0] !== 1'b1 || fresh[0] !== 1'b1) begin
      bad++; $display("FAIL drop_saturate drop=%h pv=%b fr=%b exp=F/1/1", dcnt(0), prod_valid[0], fresh[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (prod_valid !== '0 || fresh !== '0 || drop_cnt !== '0 || prod_addr !== BASE_PACK) begin
      bad++; $display("FAIL async_reset pv=%b fr=%b drop=%h addr=%h", prod_valid, fresh, drop_cnt, prod_addr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(3'b001, 3'b000, 3'b000, 3'b000);
    total++; if (paddr(0) !== 26'h01000000 || dcnt(0) !== 4'd0) begin
      bad++; $display("FAIL post_reset_acq addr=%h drop=%0d exp=01000000/0", paddr(0), dcnt(0));
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] pa, pc, ca, cr;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NCH; c++) begin
        pa[c] = ($urandom_range(0, 9) < 5);
        pc[c] = ($urandom_range(0, 9) < 4);
        ca[c] = ($urandom_range(0, 9) < 3);
        cr[c] = ($urandom_range(0, 9) < 2);
      end
      cycle(pa, pc, ca, cr);
      for (int c = 0; c < NCH; c++) begin
        total++; if (prod_valid[c] !== (m_w[c] >= 0) || (m_w[c] >= 0 && paddr(c) !== exp_addr(c, m_w[c]))) begin
          bad++; $display("FAIL rnd_prod ch%0d n%0d v=%b addr=%h exp_idx=%0d", c, n, prod_valid[c], paddr(c), m_w[c]);
        end
        total++; if (cons_valid[c] !== (m_c[c] >= 0) || (m_c[c] >= 0 && caddr(c) !== exp_addr(c, m_c[c]))) begin
          bad++; $display("FAIL rnd_cons ch%0d n%0d v=%b addr=%h exp_idx=%0d", c, n, cons_valid[c], caddr(c), m_c[c]);
        end
        total++; if (fresh[c] !== (m_r[c] >= 0) || dcnt(c) !== DW'(m_drop[c]) || proto_err[c] !== m_err[c]) begin
          bad++; $display("FAIL rnd_flags ch%0d n%0d fresh=%b drop=%0d err=%b exp=%0b/%0d/%b",
                          c, n, fresh[c], dcnt(c), proto_err[c], (m_r[c] >= 0), m_drop[c], m_err[c]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    prod_acq = '0; prod_commit = '0; cons_acq = '0; cons_rel = '0;
    model_reset();
    test_reset();
    test_prod_acq();
    test_drop_and_consume();
    test_commit_with_cons_acq();
    test_proto_err();
    test_saturate_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
